control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus 32-bit datapath: one-hot step counter with fetch and per-class execute.
// Define CTRL_MEM_WAIT_EN to stretch memory steps until mem_rdy; otherwise every memory step lasts one cycle.
module control_sequencer #(
    parameter int STEPS = 8,
    parameter int OPW   = 5
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           mem_rdy,
    input  logic           stop,
    output logic           pc_out,
    output logic           mdr_out,
    output logic           z_hi_out,
    output logic           z_lo_out,
    output logic           hi_out,
    output logic           lo_out,
    output logic           in_port_out,
    output logic           c_out,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           r_in,
    output logic           r_out,
    output logic           ba_out,
    output logic           pc_in,
    output logic           inc_pc,
    output logic           ir_in,
    output logic           mar_in,
    output logic           mdr_in,
    output logic           y_in,
    output logic           z_in,
    output logic           hi_in,
    output logic           lo_in,
    output logic           out_port_in,
    output logic           con_in,
    output logic           read,
    output logic           write,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           illegal
);
    localparam int SW = STEPS + 1;

    typedef enum logic [SW-1:0] {
        T0   = SW'(1),
        T1   = SW'(2),
        T2   = SW'(4),
        T3   = SW'(8),
        T4   = SW'(16),
        T5   = SW'(32),
        T6   = SW'(64),
        T7   = SW'(128),
        HALT = SW'(256)
    } step_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(10);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(11);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(14);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(16);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(17);
    localparam logic [OPW-1:0] OP_BR   = OPW'(18);
    localparam logic [OPW-1:0] OP_JR   = OPW'(19);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(20);
    localparam logic [OPW-1:0] OP_IN   = OPW'(21);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(22);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(23);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(24);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(25);
    localparam logic [OPW-1:0] OP_HALT = OPW'(26);

    step_t          step_reg;
    logic           illegal_reg;
    logic [OPW-1:0] opcode;
    logic           mem_ok;
    logic           unused_ir;

    assign opcode    = ir[31:32-OPW];
    assign unused_ir = ^ir[31-OPW:0];

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign mem_ok         = 1'b1;
`endif

    logic is_ld, is_ldi, is_st, is_alu_r, is_alu_i, is_unary, is_muldiv, is_br, is_jal;
    logic is_stop_op, is_bad, last_t3, last_t4, last_t5, last_t6;

    assign is_ld      = (opcode == OP_LD);
    assign is_ldi     = (opcode == OP_LDI);
    assign is_st      = (opcode == OP_ST);
    assign is_alu_r   = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    assign is_alu_i   = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_muldiv  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_br      = (opcode == OP_BR);
    assign is_jal     = (opcode == OP_JAL);
    assign is_bad     = (opcode > OP_HALT);
    assign is_stop_op = (opcode >= OP_HALT);
    assign last_t3    = (opcode >= OP_IN && opcode <= OP_NOP) || (opcode == OP_JR);
    assign last_t4    = is_unary || is_jal;
    assign last_t5    = is_alu_r || is_alu_i || is_ldi;
    assign last_t6    = is_muldiv || is_br;

    // stop is only honoured on the edge that would start the next fetch
    step_t end_step;
    assign end_step = stop ? HALT : T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            step_reg    <= T0;
            illegal_reg <= 1'b0;
        end else begin
            case (step_reg)
                T0: step_reg <= T1;
                T1: if (mem_ok) step_reg <= T2;
                T2: step_reg <= T3;
                T3: begin
                    if (is_stop_op) begin
                        step_reg    <= HALT;
                        illegal_reg <= is_bad;
                    end else if (last_t3) begin
                        step_reg <= end_step;
                    end else begin
                        step_reg <= T4;
                    end
                end
                T4: step_reg <= last_t4 ? end_step : T5;
                T5: step_reg <= last_t5 ? end_step : T6;
                T6: begin
                    if (is_ld) begin
                        if (mem_ok) step_reg <= T7;
                    end else if (last_t6) begin
                        step_reg <= end_step;
                    end else begin
                        step_reg <= T7;
                    end
                end
                T7:   if (!is_st || mem_ok) step_reg <= end_step;
                HALT: step_reg <= HALT;
                default: step_reg <= T0;
            endcase
        end
    end

    // halt/illegal are recognised while still in T3 so run drops straight after fetch
    assign run     = clr || !((step_reg == HALT) || (step_reg == T3 && is_stop_op));
    assign illegal = !clr && (illegal_reg || (step_reg == T3 && is_bad));

    always_comb begin
        pc_out = 1'b0; mdr_out = 1'b0; z_hi_out = 1'b0; z_lo_out = 1'b0;
        hi_out = 1'b0; lo_out = 1'b0; in_port_out = 1'b0; c_out = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
        pc_in = 1'b0; inc_pc = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
        y_in = 1'b0; z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; out_port_in = 1'b0;
        con_in = 1'b0; read = 1'b0; write = 1'b0;
        alu_op = '0;
        if (!clr) begin
            case (step_reg)
                T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
                T1: begin z_lo_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
                T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
                T3: begin
                    if (is_alu_r || is_alu_i) begin
                        grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                    end else if (is_unary) begin
                        grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = opcode;
                    end else if (is_muldiv) begin
                        gra = 1'b1; r_out = 1'b1; y_in = 1'b1;
                    end else if (is_ld || is_ldi || is_st) begin
                        grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                    end else if (is_br) begin
                        gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
                    end else if (opcode == OP_JR) begin
                        gra = 1'b1; r_out = 1'b1; pc_in = 1'b1;
                    end else if (is_jal) begin
                        pc_out = 1'b1; r_in = 1'b1;
                    end else if (opcode == OP_IN) begin
                        in_port_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        gra = 1'b1; r_out = 1'b1; out_port_in = 1'b1;
                    end else if (opcode == OP_MFHI) begin
                        hi_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else if (opcode == OP_MFLO) begin
                        lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                end
                T4: begin
                    if (is_alu_r) begin
                        grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = opcode;
                    end else if (is_alu_i) begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = opcode;
                    end else if (is_unary) begin
                        z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else if (is_muldiv) begin
                        grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = opcode;
                    end else if (is_ld || is_ldi || is_st) begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = OP_ADD;
                    end else if (is_br) begin
                        pc_out = 1'b1; y_in = 1'b1;
                    end else if (is_jal) begin
                        gra = 1'b1; r_out = 1'b1; pc_in = 1'b1;
                    end
                end
                T5: begin
                    if (is_alu_r || is_alu_i || is_ldi) begin
                        z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else if (is_muldiv) begin
                        z_lo_out = 1'b1; lo_in = 1'b1;
                    end else if (is_ld || is_st) begin
                        z_lo_out = 1'b1; mar_in = 1'b1;
                    end else if (is_br) begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = OP_ADD;
                    end
                end
                T6: begin
                    if (is_muldiv) begin
                        z_hi_out = 1'b1; hi_in = 1'b1;
                    end else if (is_ld) begin
                        read = 1'b1; mdr_in = 1'b1;
                    end else if (is_st) begin
                        gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
                    end else if (is_br && con_ff) begin
                        z_lo_out = 1'b1; pc_in = 1'b1;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else if (is_st) begin
                        write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-step control vectors against a table of the instruction set.
module tb_control_sequencer;
`ifdef CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr, con_ff, mem_rdy, stop;
    logic [31:0] ir;
    logic pc_out, mdr_out, z_hi_out, z_lo_out, hi_out, lo_out, in_port_out, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, out_port_in, con_in;
    logic read, write, run, illegal;
    logic [4:0] alu_op;

    int total = 0;
    int bad   = 0;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy), .stop(stop),
        .pc_out(pc_out), .mdr_out(mdr_out), .z_hi_out(z_hi_out), .z_lo_out(z_lo_out),
        .hi_out(hi_out), .lo_out(lo_out), .in_port_out(in_port_out), .c_out(c_out),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .out_port_in(out_port_in),
        .con_in(con_in), .read(read), .write(write), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [26:0] dut_vec;
    assign dut_vec = {pc_out, mdr_out, z_hi_out, z_lo_out, hi_out, lo_out, in_port_out, c_out,
                      gra, grb, grc, r_in, r_out, ba_out,
                      pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, out_port_in, con_in,
                      read, write};

    localparam logic [26:0] PC_OUT = 27'(1) << 26, MDR_OUT = 27'(1) << 25, Z_HI_OUT = 27'(1) << 24;
    localparam logic [26:0] Z_LO_OUT = 27'(1) << 23, HI_OUT = 27'(1) << 22, LO_OUT = 27'(1) << 21;
    localparam logic [26:0] IN_PORT_OUT = 27'(1) << 20, C_OUT = 27'(1) << 19, GRA = 27'(1) << 18;
    localparam logic [26:0] GRB = 27'(1) << 17, GRC = 27'(1) << 16, R_IN = 27'(1) << 15;
    localparam logic [26:0] R_OUT = 27'(1) << 14, BA_OUT = 27'(1) << 13, PC_IN = 27'(1) << 12;
    localparam logic [26:0] INC_PC = 27'(1) << 11, IR_IN = 27'(1) << 10, MAR_IN = 27'(1) << 9;
    localparam logic [26:0] MDR_IN = 27'(1) << 8, Y_IN = 27'(1) << 7, Z_IN = 27'(1) << 6;
    localparam logic [26:0] HI_IN = 27'(1) << 5, LO_IN = 27'(1) << 4, OUT_PORT_IN = 27'(1) << 3;
    localparam logic [26:0] CON_IN = 27'(1) << 2, READ = 27'(1) << 1, WRITE = 27'(1);
    localparam logic [26:0] T0_VEC = PC_OUT | MAR_IN | INC_PC | Z_IN;

    // Expected {alu_op, controls} for step k of an instruction, straight from the instruction table.
    function automatic logic [31:0] exp_ctrl(input logic [4:0] op, input int k, input logic con);
        logic [26:0] v = '0;
        logic [4:0]  a = '0;
        if (k == 0) v = T0_VEC;
        else if (k == 1) v = Z_LO_OUT | PC_IN | READ | MDR_IN;
        else if (k == 2) v = MDR_OUT | IR_IN;
        else if (op >= 5'h03 && op <= 5'h0D) begin
            if (k == 3) v = GRB | R_OUT | Y_IN;
            if (k == 4) begin v = ((op <= 5'h0A) ? (GRC | R_OUT) : C_OUT) | Z_IN; a = op; end
            if (k == 5) v = Z_LO_OUT | GRA | R_IN;
        end else if (op == 5'h10 || op == 5'h11) begin
            if (k == 3) begin v = GRB | R_OUT | Z_IN; a = op; end
            if (k == 4) v = Z_LO_OUT | GRA | R_IN;
        end else if (op == 5'h0E || op == 5'h0F) begin
            if (k == 3) v = GRA | R_OUT | Y_IN;
            if (k == 4) begin v = GRB | R_OUT | Z_IN; a = op; end
            if (k == 5) v = Z_LO_OUT | LO_IN;
            if (k == 6) v = Z_HI_OUT | HI_IN;
        end else if (op <= 5'h02) begin
            if (k == 3) v = GRB | BA_OUT | Y_IN;
            if (k == 4) begin v = C_OUT | Z_IN; a = 5'h03; end
            if (k == 5) v = (op == 5'h01) ? (Z_LO_OUT | GRA | R_IN) : (Z_LO_OUT | MAR_IN);
            if (k == 6) v = (op == 5'h00) ? (READ | MDR_IN) : (GRA | R_OUT | MDR_IN);
            if (k == 7) v = (op == 5'h00) ? (MDR_OUT | GRA | R_IN) : WRITE;
        end else if (op == 5'h12) begin
            if (k == 3) v = GRA | R_OUT | CON_IN;
            if (k == 4) v = PC_OUT | Y_IN;
            if (k == 5) begin v = C_OUT | Z_IN; a = 5'h03; end
            if (k == 6) v = con ? (Z_LO_OUT | PC_IN) : 27'(0);
        end else if (op == 5'h13) v = GRA | R_OUT | PC_IN;
        else if (op == 5'h14) v = (k == 3) ? (PC_OUT | R_IN) : (GRA | R_OUT | PC_IN);
        else if (op == 5'h15) v = IN_PORT_OUT | GRA | R_IN;
        else if (op == 5'h16) v = GRA | R_OUT | OUT_PORT_IN;
        else if (op == 5'h17) v = HI_OUT | GRA | R_IN;
        else if (op == 5'h18) v = LO_OUT | GRA | R_IN;
        return {a, v};
    endfunction

    function automatic int last_step(input logic [4:0] op);
        if (op == 5'h00 || op == 5'h02) return 7;
        if (op == 5'h0E || op == 5'h0F || op == 5'h12) return 6;
        if (op == 5'h01 || (op >= 5'h03 && op <= 5'h0D)) return 5;
        if (op == 5'h10 || op == 5'h11 || op == 5'h14) return 4;
        return 3;
    endfunction

    function automatic bit mem_step(input logic [4:0] op, input int k);
        return (k == 1) || (op == 5'h00 && k == 6) || (op == 5'h02 && k == 7);
    endfunction

    // Drives one instruction from T0, checking every cycle; optional clr abort at step abort_at,
    // stop held from step stop_at, and stall_n cycles of mem_rdy=0 at each memory step.
    task automatic drive_instr(input logic [4:0] op, input logic con, input int stall_n,
                               input int abort_at, input int stop_at, output int ncyc);
        int k, wait_cnt;
        bit done, exp_run, exp_ill;
        logic [31:0] e;
        k = 0; wait_cnt = 0; ncyc = 0; done = 0;
        ir = {op, 27'($urandom)};
        con_ff = con;
        while (!done) begin
            clr     = (k == abort_at);
            stop    = (stop_at >= 0 && k >= stop_at);
            mem_rdy = !(mem_step(op, k) && wait_cnt < stall_n);
            e       = clr ? 32'h0 : exp_ctrl(op, k, con);
            exp_run = clr || !(k == 3 && op >= 5'h1A);
            exp_ill = !clr && (k == 3 && op >= 5'h1B);
            @(negedge clk);
            total++;
            if ({alu_op, dut_vec} !== e) begin
                bad++;
                $display("FAIL ctrl op=%h step=%0d got=%h exp=%h", op, k, {alu_op, dut_vec}, e);
            end
            total++;
            if (run !== exp_run) begin
                bad++;
                $display("FAIL run op=%h step=%0d got=%b exp=%b", op, k, run, exp_run);
            end
            total++;
            if (illegal !== exp_ill) begin
                bad++;
                $display("FAIL illegal op=%h step=%0d got=%b exp=%b", op, k, illegal, exp_ill);
            end
            @(posedge clk); #1;
            ncyc++;
            if (clr) done = 1;
            else if (WAIT_EN && !mem_rdy) wait_cnt++;
            else if (k == last_step(op)) done = 1;
            else begin k++; wait_cnt = 0; end
            if (ncyc > 64) begin
                total++; bad++;
                $display("FAIL timeout op=%h got=%0d cycles exp=<=64", op, ncyc);
                done = 1;
            end
        end
        clr = 1'b0; stop = 1'b0; mem_rdy = 1'b1;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b1; stop = 1'b0; mem_rdy = 1'b1; con_ff = 1'b0; ir = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== 27'(0) || alu_op !== 5'h0 || run !== 1'b1 || illegal !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold got=%h/%h run=%b ill=%b exp=0/0 run=1 ill=0", dut_vec, alu_op, run, illegal);
            end
            @(posedge clk); #1;
        end
        clr = 1'b0;
        @(negedge clk);
        total++;
        if (dut_vec !== T0_VEC || run !== 1'b1 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_t0 got=%h run=%b ill=%b exp=%h run=1 ill=0", dut_vec, run, illegal, T0_VEC);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_alu_add;
        int n;
        drive_instr(5'h03, 1'b0, 0, -1, -1, n);
        total++;
        if (n !== 6) begin bad++; $display("FAIL add_len got=%0d exp=6", n); end
    endtask

    task automatic test_mem_wait;
        int n, exp_n;
        exp_n = 8 + (WAIT_EN ? 6 : 0);
        drive_instr(5'h00, 1'b0, 3, -1, -1, n);
        total++;
        if (n !== exp_n) begin bad++; $display("FAIL ld_len got=%0d exp=%0d", n, exp_n); end
        drive_instr(5'h02, 1'b0, 3, -1, -1, n);
        total++;
        if (n !== exp_n) begin bad++; $display("FAIL st_len got=%0d exp=%0d", n, exp_n); end
    endtask

    task automatic test_branch;
        int n;
        drive_instr(5'h12, 1'b0, 0, -1, -1, n);
        drive_instr(5'h12, 1'b1, 0, -1, -1, n);
        total++;
        if (n !== 7) begin bad++; $display("FAIL br_len got=%0d exp=7", n); end
    endtask

    task automatic test_back_to_back;
        int n, exp_n, st;
        logic [4:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 25));
            st = $urandom_range(0, 2);
            exp_n = last_step(op) + 1;
            if (WAIT_EN) exp_n += st * ((op == 5'h00 || op == 5'h02) ? 2 : 1);
            drive_instr(op, 1'($urandom), st, -1, -1, n);
            total++;
            if (n !== exp_n) begin bad++; $display("FAIL rand_len op=%h got=%0d exp=%0d", op, n, exp_n); end
        end
    endtask

    task automatic test_stop_clr;
        int n;
        drive_instr(5'h04, 1'b0, 0, -1, 4, n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== 27'(0) || alu_op !== 5'h0 || run !== 1'b0 || illegal !== 1'b0) begin
                bad++;
                $display("FAIL stop_halt got=%h/%h run=%b ill=%b exp=0/0 run=0 ill=0", dut_vec, alu_op, run, illegal);
            end
            @(posedge clk); #1;
        end
        do_clr();
        drive_instr(5'h0E, 1'b0, 0, 3, -1, n);
        drive_instr(5'h0F, 1'b1, 0, -1, -1, n);
        total++;
        if (n !== 7) begin bad++; $display("FAIL div_len got=%0d exp=7", n); end
    endtask

    task automatic test_halt_ops(input logic [4:0] op);
        int n;
        bit exp_ill;
        exp_ill = (op >= 5'h1B);
        drive_instr(op, 1'b0, 0, -1, -1, n);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== 27'(0) || run !== 1'b0 || illegal !== exp_ill) begin
                bad++;
                $display("FAIL halt_state op=%h got=%h run=%b ill=%b exp=0 run=0 ill=%b", op, dut_vec, run, illegal, exp_ill);
            end
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(negedge clk);
        total++;
        if (run !== 1'b1 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL halt_clr op=%h run=%b ill=%b exp=run=1 ill=0", op, run, illegal);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        drive_instr(5'h19, 1'b0, 0, -1, -1, n);
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_mem_wait();
        test_branch();
        test_back_to_back();
        test_stop_clr();
        test_halt_ops(5'h1D);
        test_halt_ops(5'h1A);
        test_halt_ops(5'h1F);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
